dmem_responder: RTL and testbench

Data-memory responder for the five-stage pipeline: the target end of the MEM-stage bus, which carries write strobe, address, store data, access type and load data. It provides word-organised RAM with byte and halfword store merging, load extraction with sign or zero extension, and a sticky misalignment fault. It also decodes a small memory-mapped I/O window containing a free-running cycle counter and a debug transmit FIFO that a testbench or host drains over a valid/ready port.

---
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// MEM-stage bus plus debug TX drain port between the pipeline/host and dmem_responder.
// Pure wiring; no latency of its own.
// The debug port uses valid/ready, and the MEM bus has no backpressure.
interface dmem_responder_if #(
    parameter int FIFO_DEPTH = 4
) ();
    logic                          mem_w;
    logic [31:0]                   addr;
    logic [31:0]                   wdata;
    logic [2:0]                    dm_type;
    logic [31:0]                   rdata;
    logic                          misalign;
    logic [31:0]                   misalign_addr;
    logic                          dbg_valid;
    logic [31:0]                   dbg_data;
    logic                          dbg_ready;
    logic [$clog2(FIFO_DEPTH):0]   dbg_count;

    modport master (
        output mem_w, addr, wdata, dm_type, dbg_ready,
        input  rdata, misalign, misalign_addr, dbg_valid, dbg_data, dbg_count
    );

    modport slave (
        input  mem_w, addr, wdata, dm_type, dbg_ready,
        output rdata, misalign, misalign_addr, dbg_valid, dbg_data, dbg_count
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with sub-word merge/extract, sticky misalign fault; DMEM_MMIO_EN adds cycle counter + debug TX FIFO.
// Loads are combinational (0 cycles); stores and pushes commit on the clk edge.
// Debug FIFO drains on dbg_valid & dbg_ready; pushes to a full FIFO with no pop are dropped and flag overflow.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   ram_word;
    logic          is_half, is_byte, sign_ext;
    logic          mmio_hit, misaligned, status_wr, ram_we;
    logic [31:0]   mmio_rd;
    logic [7:0]    lane8;
    logic [15:0]   lane16;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic          unused_addr_bits;

    assign word_idx         = bus.addr[AW+1:2];
    assign ram_word         = ram[word_idx];
    assign unused_addr_bits = ^bus.addr[31:AW+2];

    always_comb begin
        is_half  = (bus.dm_type == 3'd1) || (bus.dm_type == 3'd2);
        is_byte  = (bus.dm_type == 3'd3) || (bus.dm_type == 3'd4);
        sign_ext = (bus.dm_type == 3'd1) || (bus.dm_type == 3'd3);
    end

    // MMIO registers are word-only, so any nonzero low bits fault there.
    always_comb begin
        misaligned = 1'b0;
        if (mmio_hit)
            misaligned = (bus.addr[1:0] != 2'b00);
        else if (is_half)
            misaligned = bus.addr[0];
        else if (!is_byte)
            misaligned = (bus.addr[1:0] != 2'b00);
    end

    always_comb begin
        lane8     = ram_word[{bus.addr[1:0], 3'b000} +: 8];
        lane16    = bus.addr[1] ? ram_word[31:16] : ram_word[15:0];
        bus.rdata = '0;
        if (misaligned)
            bus.rdata = '0;
        else if (mmio_hit)
            bus.rdata = mmio_rd;
        else if (is_byte)
            bus.rdata = {{24{sign_ext & lane8[7]}}, lane8};
        else if (is_half)
            bus.rdata = {{16{sign_ext & lane16[15]}}, lane16};
        else
            bus.rdata = ram_word;
    end

    always_comb begin
        be    = 4'hF;
        wword = bus.wdata;
        if (is_byte) begin
            be    = 4'b0001 << bus.addr[1:0];
            wword = {4{bus.wdata[7:0]}};
        end else if (is_half) begin
            be    = bus.addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{bus.wdata[15:0]}};
        end
    end

    assign ram_we = bus.mem_w && !reset && !misaligned && !mmio_hit;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    ram[word_idx][8*i +: 8] <= wword[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.misalign      <= 1'b0;
            bus.misalign_addr <= '0;
        end else if (status_wr && bus.wdata[1]) begin
            bus.misalign <= 1'b0;
        end else if (bus.mem_w && misaligned) begin
            bus.misalign <= 1'b1;
            if (!bus.misalign)
                bus.misalign_addr <= bus.addr;
        end
    end

`ifdef DMEM_MMIO_EN
    logic [63:0]   cycle_cnt;
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow, full, push, pop, push_ok;

    assign mmio_hit  = (bus.addr[31:4] == 28'hFFFFFF0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push      = bus.mem_w && mmio_hit && !misaligned && (bus.addr[3:2] == 2'd2);
    assign status_wr = bus.mem_w && mmio_hit && !misaligned && (bus.addr[3:2] == 2'd3);
    assign pop       = (count != '0) && bus.dbg_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            fifo_mem[wr_ptr] <= bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (!push_ok && pop)
                count <= count - CW'(1);
            if (status_wr && bus.wdata[2])
                overflow <= 1'b0;
            else if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        unique case (bus.addr[3:2])
            2'd0:    mmio_rd = cycle_cnt[31:0];
            2'd1:    mmio_rd = cycle_cnt[63:32];
            2'd2:    mmio_rd = '0;
            default: mmio_rd = {29'b0, overflow, bus.misalign, full};
        endcase
    end

    assign bus.dbg_valid = (count != '0);
    assign bus.dbg_data  = bus.dbg_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.dbg_count = count;
`else
    logic unused_dbg_ready;

    assign mmio_hit         = 1'b0;
    assign status_wr        = 1'b0;
    assign mmio_rd          = '0;
    assign unused_dbg_ready = bus.dbg_ready;
    assign bus.dbg_valid    = 1'b0;
    assign bus.dbg_data     = '0;
    assign bus.dbg_count    = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; MMIO steps are compiled in with DMEM_MMIO_EN.
module tb_dmem_responder;
    logic clk;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    dmem_responder_if #(.FIFO_DEPTH(4)) bus ();

    dmem_responder #(.DEPTH_WORDS(1024), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        bus.mem_w   = 1'b1;
        bus.addr    = a;
        bus.wdata   = d;
        bus.dm_type = t;
        tick();
        bus.mem_w = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] t);
        bus.addr    = a;
        bus.dm_type = t;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_w     = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.dm_type   = 3'd0;
        bus.dbg_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        chk("rst_misalign_addr", bus.misalign_addr, 32'd0);
        chk("rst_dbg_valid", 32'(bus.dbg_valid), 32'd0);
        chk("rst_dbg_count", 32'(bus.dbg_count), 32'd0);
        chk("rst_dbg_data", bus.dbg_data, 32'd0);

        // byte merge and byte extraction
        store(32'h10, 32'h11223344, 3'd0);
        store(32'h11, 32'h000000AA, 3'd3);
        load(32'h10, 3'd0);  chk("merge_word", bus.rdata, 32'h1122AA44);
        load(32'h11, 3'd3);  chk("byte_signed", bus.rdata, 32'hFFFFFFAA);
        load(32'h11, 3'd4);  chk("byte_unsigned", bus.rdata, 32'h000000AA);
        load(32'h13, 3'd4);  chk("byte_lane3", bus.rdata, 32'h00000011);
        load(32'h10, 3'd5);  chk("type5_as_word", bus.rdata, 32'h1122AA44);

        // half merge and extraction
        store(32'h20, 32'h00000000, 3'd0);
        store(32'h22, 32'h00008001, 3'd1);
        load(32'h22, 3'd1);  chk("half_signed", bus.rdata, 32'hFFFF8001);
        load(32'h22, 3'd2);  chk("half_unsigned", bus.rdata, 32'h00008001);
        load(32'h20, 3'd0);  chk("half_in_word", bus.rdata, 32'h80010000);

        // load in the commit cycle sees old data, next cycle sees new
        bus.mem_w   = 1'b1;
        bus.addr    = 32'h20;
        bus.wdata   = 32'hDEADBEEF;
        bus.dm_type = 3'd0;
        #1;
        chk("same_cycle_old", bus.rdata, 32'h80010000);
        tick();
        bus.mem_w = 1'b0;
        chk("next_cycle_new", bus.rdata, 32'hDEADBEEF);

        // misalignment
        store(32'h13, 32'hFFFFFFFF, 3'd0);
        chk("mis_flag", 32'(bus.misalign), 32'd1);
        chk("mis_addr", bus.misalign_addr, 32'h13);
        load(32'h10, 3'd0);  chk("mis_ram_unchanged", bus.rdata, 32'h1122AA44);
        load(32'h13, 3'd0);  chk("mis_load_zero", bus.rdata, 32'd0);
        load(32'h21, 3'd1);  chk("mis_half_load_zero", bus.rdata, 32'd0);
        store(32'h15, 32'h0, 3'd0);
        chk("mis_addr_kept", bus.misalign_addr, 32'h13);
        store(32'h23, 32'h1234, 3'd2);
        load(32'h20, 3'd0);  chk("mis_half_no_write", bus.rdata, 32'hDEADBEEF);
        chk("mis_still_set", 32'(bus.misalign), 32'd1);

        // address wrap
        store(32'h1010, 32'h0BADF00D, 3'd0);
        load(32'h10, 3'd0);  chk("addr_wrap", bus.rdata, 32'h0BADF00D);

`ifndef DMEM_MMIO_EN
        store(32'hFFFFFF08, 32'hCAFEF00D, 3'd0);
        load(32'h00000F08, 3'd0); chk("window_is_ram", bus.rdata, 32'hCAFEF00D);
        chk("no_dbg_valid", 32'(bus.dbg_valid), 32'd0);
`endif

        // reset suppresses a coincident store and clears misalign
        store(32'h40, 32'h0, 3'd0);
        reset = 1'b1;
        store(32'h40, 32'h55, 3'd0);
        reset = 1'b0;
        load(32'h40, 3'd0);  chk("reset_blocks_store", bus.rdata, 32'd0);
        chk("reset_clears_mis", 32'(bus.misalign), 32'd0);

`ifdef DMEM_MMIO_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        load(32'hFFFFFF00, 3'd0); chk("cycle_lo_10", bus.rdata, 32'd10);
        load(32'hFFFFFF04, 3'd0); chk("cycle_hi_0", bus.rdata, 32'd0);
        load(32'hFFFFFF08, 3'd0); chk("dbg_tx_read0", bus.rdata, 32'd0);

        // overflow with consumer stalled
        bus.dbg_ready = 1'b0;
        store(32'h00000F08, 32'h0, 3'd0);
        for (int i = 1; i <= 5; i++)
            store(32'hFFFFFF08, 32'(i), 3'd0);
        chk("fifo_count_4", 32'(bus.dbg_count), 32'd4);
        chk("fifo_head_1", bus.dbg_data, 32'd1);
        load(32'hFFFFFF0C, 3'd0); chk("status_ovf_full", bus.rdata, 32'h5);
        load(32'h00000F08, 3'd0); chk("mmio_no_alias", bus.rdata, 32'd0);

        bus.dbg_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", bus.dbg_data, 32'(i));
            tick();
        end
        chk("drained_valid", 32'(bus.dbg_valid), 32'd0);
        bus.dbg_ready = 1'b0;

        store(32'hFFFFFF0C, 32'h4, 3'd0);
        load(32'hFFFFFF0C, 3'd0); chk("ovf_cleared", bus.rdata, 32'h0);

        // push and pop together while full
        for (int i = 10; i <= 13; i++)
            store(32'hFFFFFF08, 32'(i), 3'd0);
        bus.dbg_ready = 1'b1;
        store(32'hFFFFFF08, 32'd9, 3'd0);
        bus.dbg_ready = 1'b0;
        chk("full_pushpop_count", 32'(bus.dbg_count), 32'd4);
        chk("full_pushpop_head", bus.dbg_data, 32'd11);
        load(32'hFFFFFF0C, 3'd0); chk("full_no_ovf", bus.rdata, 32'h1);
        bus.dbg_ready = 1'b1;
        repeat (3) tick();
        chk("tail_is_9", bus.dbg_data, 32'd9);
        tick();
        chk("empty_again", 32'(bus.dbg_valid), 32'd0);

        // push and pop together while empty
        store(32'hFFFFFF08, 32'd7, 3'd0);
        chk("empty_push_valid", 32'(bus.dbg_valid), 32'd1);
        chk("empty_push_data", bus.dbg_data, 32'd7);
        chk("empty_push_count", 32'(bus.dbg_count), 32'd1);
        tick();
        chk("empty_push_popped", 32'(bus.dbg_count), 32'd0);
        bus.dbg_ready = 1'b0;

        // sub-word MMIO access faults and does not push
        store(32'hFFFFFF09, 32'h77, 3'd3);
        chk("mmio_sub_mis", 32'(bus.misalign), 32'd1);
        chk("mmio_sub_addr", bus.misalign_addr, 32'hFFFFFF09);
        chk("mmio_sub_nopush", 32'(bus.dbg_count), 32'd0);
        store(32'hFFFFFF0C, 32'h2, 3'd0);
        chk("status_clr_mis", 32'(bus.misalign), 32'd0);
        store(32'h13, 32'h0, 3'd0);
        chk("mis13_set", 32'(bus.misalign), 32'd1);
        store(32'hFFFFFF0C, 32'h2, 3'd0);
        chk("mis13_clr", 32'(bus.misalign), 32'd0);

        // reset mid-drain with coincident push
        for (int i = 1; i <= 3; i++)
            store(32'hFFFFFF08, 32'(i), 3'd0);
        bus.dbg_ready = 1'b1;
        tick();
        reset = 1'b1;
        store(32'hFFFFFF08, 32'h99, 3'd0);
        reset = 1'b0;
        chk("rst_drain_valid", 32'(bus.dbg_valid), 32'd0);
        chk("rst_drain_count", 32'(bus.dbg_count), 32'd0);
        load(32'hFFFFFF00, 3'd0); chk("cycle_after_rst", bus.rdata, 32'd0);
        bus.dbg_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
